pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Program-counter and fetch-request stage of the MIPS_32 front end.
- Consumes the word-aligned branch offset produced by the left-shift-by-2 offset shifter. Adds it to the branch instruction's PC+4 to form the branch target.
- Owns the PC register, sequential increment, branch/jump redirect, and the valid/ready fetch handshake to instruction memory.
- Emits a one-cycle flush to the IF/ID register on every redirect.

Parameters:
- SIZE, 32, datapath/address width in bits.
- SHIFT_N, 2, alignment shift; instruction size is 1<<SHIFT_N bytes (4). Must match the offset shifter's SHIFT_N.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard unit holds fetch; PC does not advance sequentially.
- branch_taken  input  1  branch resolved taken this cycle; qualified by ID stage.
- branch_base  input  SIZE  PC+4 of the branch instruction.
- branch_offset  input  SIZE  sign-extended immediate already shifted left by SHIFT_N.
- jump  input  1  unconditional jump this cycle; qualified by ID stage.
- jump_target  input  SIZE  absolute jump target.
- imem_ready  input  1  instruction memory accepts the request this cycle.
- imem_valid  output  1  fetch request valid.
- pc  output  SIZE  current fetch address (registered); drives the imem address.
- pc_plus4  output  SIZE  pc + (1<<SHIFT_N), combinational from the pc register.
- flush  output  1  registered one-cycle pulse; kill the instruction in IF/ID.
- misalign_err  output  1  sticky: a redirect target had nonzero low SHIFT_N bits.

Behaviour:
- Reset: clk and rst are the only clock and reset. rst=1 asynchronously forces:
  - pc=RESET_PC
  - imem_valid=0, flush=0, misalign_err=0
  - internal state to IDLE
  - Applies mid-operation too; any in-flight redirect is discarded.
- State machine, two states:
  - IDLE (after reset) -> RUN on the first clk edge with rst=0. imem_valid=0 in IDLE and 1 in RUN.
  - RUN has no exit except reset.
  - First fetch request is therefore at RESET_PC, one cycle after reset release.
- Fetch accept: accept = imem_valid & imem_ready & ~stall.
- Next-PC priority, evaluated each edge in RUN, highest first:
  1. branch_taken=1: pc <= (branch_base + branch_offset) mod 2^SIZE. Sum truncated to SIZE bits; no overflow flag.
  2. jump=1: pc <= jump_target.
  3. accept=1: pc <= pc + (1<<SHIFT_N); wraps 0xFFFF_FFFC -> 0x0000_0000.
  4. otherwise: pc holds.
- Redirects (priorities 1 and 2) take effect regardless of stall and imem_ready. The ID stage guarantees it only asserts them for a live, non-stalled instruction.
- Redirects asserted in IDLE are ignored.
- flush is 1 for exactly the cycle after any redirect edge, else 0. Back-to-back redirects give flush high on consecutive cycles.
- Misaligned redirect target: low SHIFT_N bits are forced to 0 before loading pc, and misalign_err is set. It stays set until rst.
- Handshake rules:
  - While imem_valid=1 and the request is not accepted, pc is stable unless a redirect occurs.
  - A redirect cancels the unaccepted request; the next request is at the new pc.
  - imem_valid never drops in RUN.
- Latency:
  - Redirect edge to new pc visible: 1 cycle.
  - Sequential increment: 1 cycle after accept.
- No combinational path from any input to pc, imem_valid or flush.

Test Plan:
- Reset and start: assert rst mid-run with pc=0x40, then release, imem_ready=1.
  - During rst: pc=0, imem_valid=0, flush=0.
  - Cycle 1 after release: imem_valid=1, pc=0.
  - Following cycles: pc=4, 8, 12.
- Backpressure and stall: imem_ready=0 for 3 cycles, then stall=1 for 2 cycles with imem_ready=1.
  - pc holds at 0x10 throughout, imem_valid stays 1.
  - pc advances to 0x14 on the first cycle with stall=0.
- Branch: branch_base=0x100, branch_offset=0xFFFF_FFF0 (-16).
  - Next cycle pc=0xF0 and flush=1; the cycle after, flush=0 and pc=0xF4.
- Priority and stall override: branch_taken=1 (base 0x20, offset 0x8), jump=1 (target 0x400), stall=1, imem_ready=0, all in the same cycle.
  - pc=0x28, flush=1.
- Wrap and misalign:
  - Sequential fetch from pc=0xFFFF_FFFC: next pc=0x0000_0000.
  - Then jump_target=0x0000_0203: pc=0x200, misalign_err=1.
  - misalign_err stays 1 through later aligned jumps until rst.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request stage of the MIPS_32 front end: owns the PC,
// sequential increment, branch/jump redirect, the imem handshake and the IF/ID flush.
module pc_fetch_unit #(
    parameter int              SIZE     = 32,
    parameter int              SHIFT_N  = 2,
    parameter logic [SIZE-1:0] RESET_PC = {SIZE{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [SIZE-1:0] branch_base,
    input  logic [SIZE-1:0] branch_offset,
    input  logic            jump,
    input  logic [SIZE-1:0] jump_target,
    input  logic            imem_ready,
    output logic            imem_valid,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] pc_plus4,
    output logic            flush,
    output logic            misalign_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [SIZE-1:0] INSTR_BYTES = {{(SIZE-1){1'b0}}, 1'b1} << SHIFT_N;
    localparam logic [SIZE-1:0] LOW_MASK    = INSTR_BYTES - {{(SIZE-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [SIZE-1:0] pc_q, pc_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic            accept_s;
    logic [SIZE-1:0] target_s;
    logic            redirect_s;

    function automatic logic is_misaligned(input logic [SIZE-1:0] addr);
        return |(addr & LOW_MASK);
    endfunction

    function automatic logic [SIZE-1:0] align_addr(input logic [SIZE-1:0] addr);
        return addr & ~LOW_MASK;
    endfunction

    // Next-state, next-PC and flush/misalign computation.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        misalign_d = misalign_q;
        target_s   = pc_q;
        redirect_s = 1'b0;
        accept_s   = (state_q == RUN) & imem_ready & ~stall;

        // Branch outranks jump; the sum wraps modulo 2^SIZE with no overflow report.
        if (branch_taken) begin
            target_s   = branch_base + branch_offset;
            redirect_s = 1'b1;
        end else if (jump) begin
            target_s   = jump_target;
            redirect_s = 1'b1;
        end else begin
            target_s   = pc_q;
            redirect_s = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
                if (redirect_s) begin
                    pc_d    = align_addr(target_s);
                    flush_d = 1'b1;
                    if (is_misaligned(target_s)) begin
                        misalign_d = 1'b1;
                    end else begin
                        misalign_d = misalign_q;
                    end
                end else if (accept_s) begin
                    pc_d = pc_q + INSTR_BYTES;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // State, PC and status registers; rst clears everything asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_valid   = (state_q == RUN);
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + INSTR_BYTES;
    assign flush        = flush_q;
    assign misalign_err = misalign_q;

endmodule
